// File: rtl/safe_pkg.sv
// Shared definitions for the safe-lock password datapath: key codes,
// FSM state encoding and small decode helpers.
package safe_pkg;

   localparam logic [3:0] KEY_A        = 4'hA;
   localparam logic [3:0] KEY_B        = 4'hB;
   localparam logic [3:0] KEY_C        = 4'hD;
   localparam logic [3:0] KEY_D        = 4'hE;
   localparam logic [3:0] BLANK_NIBBLE = 4'hF;

   typedef enum logic [1:0] {
      ST_NORMAL      = 2'd0,
      ST_SET_NEW     = 2'd1,
      ST_SET_CONFIRM = 2'd2
   } pwd_state_e;

   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

endpackage

// File: rtl/pwd_entry_buf.sv
// Keypad entry buffer: appends digits left to right, backspace and clear,
// with the digit count and a display image where empty slots read BLANK_NIBBLE.
module pwd_entry_buf
   import safe_pkg::*;
#(
   parameter  int unsigned PWD_LEN = 4,
   localparam int unsigned CNT_W   = $clog2(PWD_LEN + 1),
   localparam int unsigned DISP_W  = 4 * PWD_LEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              push,
   input  logic              pop,
   input  logic [3:0]        digit,
   output logic [CNT_W-1:0]  digit_cnt,
   output logic              entry_full,
   output logic [DISP_W-1:0] entry_disp
);

   logic [3:0]       digits [PWD_LEN];
   logic [CNT_W-1:0] cnt_nxt;

   // Next count: clear wins; a full buffer ignores digits, an empty one ignores backspace.
   always_comb begin
      cnt_nxt = digit_cnt;
      if (clr)
         cnt_nxt = '0;
      else if (push && !entry_full)
         cnt_nxt = digit_cnt + CNT_W'(1);
      else if (pop && (digit_cnt != '0))
         cnt_nxt = digit_cnt - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < PWD_LEN; i++)
            digits[i] <= BLANK_NIBBLE;
         digit_cnt  <= '0;
         entry_full <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < PWD_LEN; i++) begin
            if (clr)
               digits[i] <= BLANK_NIBBLE;
            else if (push && !entry_full && (digit_cnt == CNT_W'(i)))
               digits[i] <= digit;
            else if (pop && (digit_cnt == CNT_W'(i + 1)))
               digits[i] <= BLANK_NIBBLE;
         end
         digit_cnt  <= cnt_nxt;
         entry_full <= (cnt_nxt == CNT_W'(PWD_LEN));
      end
   end

   // Digit 0 occupies the most significant nibble.
   always_comb begin
      entry_disp = '0;
      for (int unsigned i = 0; i < PWD_LEN; i++)
         entry_disp[DISP_W - 4 - 4 * i +: 4] = digits[i];
   end

endmodule

// File: rtl/pwd_store_ctrl.sv
// Password store controller: holds the stored password, reports a match of the
// entry buffer, and runs the two-pass new/confirm password setting flow.
module pwd_store_ctrl
   import safe_pkg::*;
#(
   parameter  int unsigned           PWD_LEN     = 4,
   parameter  logic [4*PWD_LEN-1:0]  DEFAULT_PWD = 16'h1234,
   localparam int unsigned           CNT_W       = $clog2(PWD_LEN + 1),
   localparam int unsigned           DISP_W      = 4 * PWD_LEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        key_value,
   input  logic              key_pulse,
   input  logic              setting_en,
   output logic              pwd_match,
   output logic              setting_done,
   output logic              set_fail,
   output logic              set_busy,
   output logic [CNT_W-1:0]  digit_cnt,
   output logic              entry_full,
   output logic [DISP_W-1:0] entry_disp
);

   pwd_state_e        state, state_nxt;
   logic              en_q;
   logic [DISP_W-1:0] temp_pwd;
   logic [DISP_W-1:0] stored_pwd;

   logic key_digit, key_conf, key_back, key_clear;
   logic en_rise;
   logic buf_clr, buf_push, buf_pop;
   logic temp_ld, stored_ld, done_nxt, fail_nxt;

   // Key decode; KEY_D and unassigned codes produce no action.
   always_comb begin
      key_digit = 1'b0;
      key_conf  = 1'b0;
      key_back  = 1'b0;
      key_clear = 1'b0;
      if (key_pulse) begin
         case (key_value)
            KEY_A:   key_conf  = 1'b1;
            KEY_B:   key_back  = 1'b1;
            KEY_C:   key_clear = 1'b1;
            KEY_D:   ;
            default: key_digit = is_digit(key_value);
         endcase
      end
   end

   assign en_rise = setting_en && !en_q;

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_NORMAL;
      else
         state <= state_nxt;
   end

   // Next state and buffer/register control; an ordinary key edits the buffer.
   always_comb begin
      state_nxt = state;
      buf_clr   = 1'b0;
      buf_push  = 1'b0;
      buf_pop   = 1'b0;
      temp_ld   = 1'b0;
      stored_ld = 1'b0;
      done_nxt  = 1'b0;
      fail_nxt  = 1'b0;
      case (state)
         ST_NORMAL: begin
            if (en_rise) begin
               state_nxt = ST_SET_NEW;
               buf_clr   = 1'b1;
            end else if (key_conf || key_clear) begin
               buf_clr = 1'b1;
            end else begin
               buf_push = key_digit;
               buf_pop  = key_back;
            end
         end
         ST_SET_NEW, ST_SET_CONFIRM: begin
            if (!setting_en) begin
               state_nxt = ST_NORMAL;
               buf_clr   = 1'b1;
            end else if (key_clear) begin
               state_nxt = ST_NORMAL;
               buf_clr   = 1'b1;
               done_nxt  = 1'b1;
               fail_nxt  = 1'b1;
            end else if (key_conf) begin
               buf_clr = 1'b1;
               if (state == ST_SET_NEW) begin
                  if (entry_full) begin
                     temp_ld   = 1'b1;
                     state_nxt = ST_SET_CONFIRM;
                  end else begin
                     fail_nxt = 1'b1;
                  end
               end else if (entry_full && (entry_disp == temp_pwd)) begin
                  stored_ld = 1'b1;
                  done_nxt  = 1'b1;
                  state_nxt = ST_NORMAL;
               end else begin
                  fail_nxt  = 1'b1;
                  state_nxt = ST_SET_NEW;
               end
            end else begin
               buf_push = key_digit;
               buf_pop  = key_back;
            end
         end
         default: begin
            state_nxt = ST_NORMAL;
            buf_clr   = 1'b1;
         end
      endcase
   end

   // Password registers and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         en_q         <= 1'b0;
         temp_pwd     <= '0;
         stored_pwd   <= DEFAULT_PWD;
         pwd_match    <= 1'b0;
         setting_done <= 1'b0;
         set_fail     <= 1'b0;
         set_busy     <= 1'b0;
      end else begin
         en_q <= setting_en;
         if (temp_ld)
            temp_pwd <= entry_disp;
         if (stored_ld)
            stored_pwd <= temp_pwd;
         pwd_match    <= (state == ST_NORMAL) && entry_full && (entry_disp == stored_pwd);
         setting_done <= done_nxt;
         set_fail     <= fail_nxt;
         set_busy     <= (state_nxt != ST_NORMAL);
      end
   end

   pwd_entry_buf #(
      .PWD_LEN (PWD_LEN)
   ) u_entry_buf (
      .clk        (clk),
      .rst        (rst),
      .clr        (buf_clr),
      .push       (buf_push),
      .pop        (buf_pop),
      .digit      (key_value),
      .digit_cnt  (digit_cnt),
      .entry_full (entry_full),
      .entry_disp (entry_disp)
   );

endmodule

// File: tb/tb_pwd_store_ctrl.sv
// Bench for pwd_store_ctrl: directed password flows plus random key traffic,
// checked every cycle against a queue-based model of the password rules.
module tb_pwd_store_ctrl;

   localparam int unsigned L   = 4;
   localparam logic [15:0] DEF = 16'h1234;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  key_value;
   logic        key_pulse;
   logic        setting_en;
   logic        pwd_match, setting_done, set_fail, set_busy, entry_full;
   logic [2:0]  digit_cnt;
   logic [15:0] entry_disp;

   int total = 0;
   int bad   = 0;

   // model: 0 = normal, 1 = entering new password, 2 = confirming
   int q[$];
   int stored_m[L];
   int temp_m[L];
   int mode;
   bit en_prev;
   bit e_match, e_done, e_fail, e_busy;
   bit en_lvl;

   pwd_store_ctrl #(.PWD_LEN(L), .DEFAULT_PWD(DEF)) dut (
      .clk          (clk),
      .rst          (rst),
      .key_value    (key_value),
      .key_pulse    (key_pulse),
      .setting_en   (setting_en),
      .pwd_match    (pwd_match),
      .setting_done (setting_done),
      .set_fail     (set_fail),
      .set_busy     (set_busy),
      .digit_cnt    (digit_cnt),
      .entry_full   (entry_full),
      .entry_disp   (entry_disp)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit q_equals(input int arr[L]);
      if (q.size() != L) return 1'b0;
      for (int i = 0; i < L; i++)
         if (q[i] != arr[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [15:0] exp_disp();
      logic [15:0] d = 16'hFFFF;
      for (int i = 0; i < q.size(); i++)
         d[4*(L-1-i) +: 4] = 4'(q[i]);
      return d;
   endfunction

   task automatic model_reset();
      mode = 0;
      q.delete();
      for (int i = 0; i < L; i++) begin
         stored_m[i] = int'((DEF >> (4 * (L - 1 - i))) & 16'hF);
         temp_m[i]   = 0;
      end
      en_prev = 1'b0;
      e_match = 1'b0;
      e_done  = 1'b0;
      e_fail  = 1'b0;
      e_busy  = 1'b0;
   endtask

   task automatic model_edit(input int k, input bit p);
      if (!p) return;
      if (k <= 9 && q.size() < L) q.push_back(k);
      else if (k == 'hB && q.size() > 0) void'(q.pop_back());
   endtask

   task automatic model_step(input int k, input bit p, input bit e);
      bit m = (mode == 0) && q_equals(stored_m);
      e_done = 1'b0;
      e_fail = 1'b0;
      if (mode == 0) begin
         if (e && !en_prev) begin
            mode = 1;
            q.delete();
         end else if (p && (k == 'hA || k == 'hD)) q.delete();
         else model_edit(k, p);
      end else if (!e) begin
         mode = 0;
         q.delete();
      end else if (p && k == 'hD) begin
         mode = 0;
         e_done = 1'b1;
         e_fail = 1'b1;
         q.delete();
      end else if (p && k == 'hA) begin
         if (mode == 1) begin
            if (q.size() == L) begin
               for (int i = 0; i < L; i++) temp_m[i] = q[i];
               mode = 2;
            end else e_fail = 1'b1;
         end else if (q_equals(temp_m)) begin
            stored_m = temp_m;
            e_done = 1'b1;
            mode = 0;
         end else begin
            e_fail = 1'b1;
            mode = 1;
         end
         q.delete();
      end else model_edit(k, p);
      en_prev = e;
      e_match = m;
      e_busy  = (mode != 0);
   endtask

   task automatic check_all();
      chk("digit_cnt", 32'(digit_cnt), 32'(q.size()));
      chk("entry_full", 32'(entry_full), 32'(q.size() == L));
      chk("entry_disp", 32'(entry_disp), 32'(exp_disp()));
      chk("pwd_match", 32'(pwd_match), 32'(e_match));
      chk("setting_done", 32'(setting_done), 32'(e_done));
      chk("set_fail", 32'(set_fail), 32'(e_fail));
      chk("set_busy", 32'(set_busy), 32'(e_busy));
   endtask

   // One clock: drive at the falling edge, model the rising edge, check at the next falling edge.
   task automatic cyc(input logic [3:0] k, input bit p, input bit e, input bit r);
      key_value  = k;
      key_pulse  = p;
      setting_en = e;
      rst        = r;
      @(posedge clk);
      if (r) model_reset();
      else   model_step(int'(k), p, e);
      @(negedge clk);
      check_all();
   endtask

   task automatic press(input logic [3:0] k);
      cyc(k, 1'b1, en_lvl, 1'b0);
      cyc(4'h0, 1'b0, en_lvl, 1'b0);
   endtask

   task automatic enter4(input logic [15:0] code);
      for (int i = 0; i < 4; i++) press(code[15 - 4*i -: 4]);
   endtask

   task automatic set_en(input bit v);
      en_lvl = v;
      cyc(4'h0, 1'b0, v, 1'b0);
      cyc(4'h0, 1'b0, v, 1'b0);
   endtask

   initial begin
      key_value  = 4'h0;
      key_pulse  = 1'b0;
      setting_en = 1'b0;
      rst        = 1'b1;
      en_lvl     = 1'b0;
      model_reset();
      @(negedge clk);
      cyc(4'h0, 1'b0, 1'b0, 1'b1);
      cyc(4'h3, 1'b1, 1'b0, 1'b1);
      cyc(4'h0, 1'b0, 1'b0, 1'b0);

      enter4(16'h1234);
      press(4'hA);
      enter4(16'h1235);
      press(4'h6);
      press(4'hB); press(4'hB);
      press(4'hB); press(4'hB); press(4'hB);
      press(4'hE); press(4'hC); press(4'hF);

      set_en(1'b1);
      enter4(16'h9876); press(4'hA);
      enter4(16'h9876); press(4'hA);
      set_en(1'b0);
      enter4(16'h9876); press(4'hA);
      enter4(16'h1234); press(4'hA);

      set_en(1'b1);
      enter4(16'h1111); press(4'hA);
      enter4(16'h1110); press(4'hA);
      press(4'h1); press(4'h2); press(4'h3); press(4'hA);
      enter4(16'h4321); press(4'hA);
      press(4'hD);
      set_en(1'b0);

      set_en(1'b1);
      enter4(16'h5555); press(4'hA);
      cyc(4'h0, 1'b0, 1'b0, 1'b1);
      en_lvl = 1'b0;
      cyc(4'h0, 1'b0, 1'b0, 1'b0);
      enter4(16'h1234); press(4'hA);

      set_en(1'b1);
      press(4'h7);
      set_en(1'b0);

      for (int n = 0; n < 4000; n++) begin
         logic [3:0] k;
         int         sel = $urandom_range(0, 9);
         bit         r   = ($urandom_range(0, 299) == 0);
         bit         p   = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 59) == 0) en_lvl = !en_lvl;
         if (sel <= 4)      k = 4'($urandom_range(0, 1));
         else if (sel <= 6) k = 4'($urandom_range(0, 9));
         else if (sel == 7) k = 4'hA;
         else if (sel == 8) k = 4'hB;
         else               k = 4'($urandom_range(12, 15));
         cyc(k, p, en_lvl, r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
